// File: rtl/mem_arb.sv
// mem_arb: two-requester memory arbiter (IFU + LSU -> one memory port).
//
// Each requester has a pending flag and a set of capture registers. A request
// is latched only while its requester is not already pending or in flight, so
// a held level never issues twice. One transaction is in flight at a time.
// When both requesters are pending, the LSU is served first.
//
// Ports
//   clock, reset_n        : rising-edge clock, async active-low reset
//   ifu_reqValid/addr     : IFU read request (pulse or level)
//   ifu_respValid/rdata   : IFU response (combinational from memory response)
//   lsu_reqValid/addr/wen/wdata/wmask : LSU load/store request
//   lsu_respValid/rdata   : LSU response (pulses for stores as well)
//   mem_req*/addr/wen/wdata/wmask     : registered memory request, valid/ready
//   mem_respValid/rdata   : memory response strobe and read data
//   mem_err               : watchdog timeout pulse
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a watchdog that
// aborts a transaction after TIMEOUT_CYCLES cycles in REQ+WAIT. Without it
// mem_err is tied 0 and the arbiter waits indefinitely.
module mem_arb #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_reqValid,
  input  logic                mem_reqReady,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err
);
  localparam int MW = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // The watchdog counter is limited to 16 bits.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_arb: TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [1:0]        state;
  logic              owner;      // 1 = LSU owns the current transaction
  logic              ifu_pend;   // pending or in flight
  logic              lsu_pend;
  logic [ADDR_W-1:0] ifu_cap_addr;
  logic [ADDR_W-1:0] lsu_cap_addr;
  logic              lsu_cap_wen;
  logic [DATA_W-1:0] lsu_cap_wdata;
  logic [MW-1:0]     lsu_cap_wmask;

  logic ifu_take, lsu_take;
  logic resp_hit;
  logic tmo_fire;   // watchdog expires this cycle
  logic tmo_resp;   // timeout response cycle (arbiter back in IDLE)

  assign ifu_take = ifu_reqValid && !ifu_pend;
  assign lsu_take = lsu_reqValid && !lsu_pend;
  assign resp_hit = (state == S_WAIT) && mem_respValid;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CLOG  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (CLOG < 8) ? 8 : ((CLOG > 16) ? 16 : CLOG);

  logic [CNT_W-1:0] tmo_cnt;

  // A real response arriving on the last allowed cycle takes precedence.
  assign tmo_fire = (state != S_IDLE) && !resp_hit &&
                    (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign tmo_resp = mem_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      mem_err <= tmo_fire;
      if (state == S_IDLE) tmo_cnt <= '0;
      else                 tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign tmo_resp = 1'b0;
  assign mem_err  = 1'b0;
`endif

  // Response routing: memory data passes straight through; a timeout answers
  // with zero data during the IDLE cycle that follows the abort.
  assign ifu_respValid = (resp_hit || tmo_resp) && !owner;
  assign lsu_respValid = (resp_hit || tmo_resp) &&  owner;
  assign ifu_rdata     = (resp_hit && !owner) ? mem_rdata : '0;
  assign lsu_rdata     = (resp_hit &&  owner) ? mem_rdata : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      owner         <= 1'b0;
      ifu_pend      <= 1'b0;
      lsu_pend      <= 1'b0;
      ifu_cap_addr  <= '0;
      lsu_cap_addr  <= '0;
      lsu_cap_wen   <= 1'b0;
      lsu_cap_wdata <= '0;
      lsu_cap_wmask <= '0;
      mem_reqValid  <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
    end else begin
      if (ifu_take) begin
        ifu_pend     <= 1'b1;
        ifu_cap_addr <= ifu_addr;
      end
      if (lsu_take) begin
        lsu_pend      <= 1'b1;
        lsu_cap_addr  <= lsu_addr;
        lsu_cap_wen   <= lsu_wen;
        lsu_cap_wdata <= lsu_wdata;
        lsu_cap_wmask <= lsu_wmask;
      end

      case (state)
        S_IDLE: begin
          if (tmo_resp) begin
            // Timeout response cycle: release the owner, no new grant yet.
            if (owner) lsu_pend <= 1'b0;
            else       ifu_pend <= 1'b0;
          end else if (lsu_pend || lsu_take) begin
            // Payload comes from the capture registers, or from the ports
            // when the request is being captured in this same cycle.
            owner        <= 1'b1;
            state        <= S_REQ;
            mem_reqValid <= 1'b1;
            mem_addr     <= lsu_pend ? lsu_cap_addr  : lsu_addr;
            mem_wen      <= lsu_pend ? lsu_cap_wen   : lsu_wen;
            mem_wdata    <= lsu_pend ? lsu_cap_wdata : lsu_wdata;
            mem_wmask    <= lsu_pend ? lsu_cap_wmask : lsu_wmask;
          end else if (ifu_pend || ifu_take) begin
            owner        <= 1'b0;
            state        <= S_REQ;
            mem_reqValid <= 1'b1;
            mem_addr     <= ifu_pend ? ifu_cap_addr : ifu_addr;
            mem_wen      <= 1'b0;
            mem_wdata    <= '0;
            mem_wmask    <= '0;
          end
        end
        S_REQ: begin
          if (tmo_fire) begin
            state        <= S_IDLE;
            mem_reqValid <= 1'b0;
          end else if (mem_reqReady) begin
            state        <= S_WAIT;
            mem_reqValid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (resp_hit) begin
            state <= S_IDLE;
            if (owner) lsu_pend <= 1'b0;
            else       ifu_pend <= 1'b0;
          end else if (tmo_fire) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
